seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
- Receive-side counterpart of the hex-to-segment encoder. Samples a multiplexed 7-segment bus (segment lines plus one-hot digit enables) and debounces each digit pattern.
- Decodes each pattern back to a 4-bit hex value and publishes a complete multi-digit frame over a valid/ready handshake.
- Used for on-chip readback/self-test of the HEX display path, e.g. checking the mine-count and timer displays.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; frame width is 4*NUM_DIGITS.
- STABLE_CYCLES, 3: consecutive identical samples required to capture a digit; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines, active-low, bit0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle
- dig_en  in  NUM_DIGITS  one-hot, active-high; selects which digit seg_in currently shows
- frame_value  out  4*NUM_DIGITS  decoded nibbles; digit k occupies bits [4k+3:4k]
- frame_err  out  NUM_DIGITS  per-digit flag: captured pattern was not a legal hex glyph
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- overrun  out  1  sticky: a complete frame was dropped while frame_valid was held

Behaviour:
- Reset (async assert, sync-released by the system): frame_value=0, frame_err=0, frame_valid=0, overrun=0, stability counter=0, all shadow digits/flags cleared, state=COLLECT.
- Inputs are synchronous to clk; the block adds no synchronizer.
- Stability:
  - Registers the previous {seg_in, dig_en}.
  - Counter resets to 1 when the sample differs from the previous one, else increments, saturating at STABLE_CYCLES.
  - dig_en zero or not one-hot: counter forced to 0, no capture.
- Capture: on the edge where the counter reaches STABLE_CYCLES (once per stable run), the selected digit's shadow nibble, shadow err and captured bit are written.
- Decode is the exact inverse of the team glyph table (active-low, segments 6..0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern: nibble 0, err=1.
- Recapturing an already-captured digit overwrites its shadow value; the last capture wins.
- FSM COLLECT:
  - When the capture edge sets the final missing captured bit, frame_value/frame_err load from shadow (including that edge's capture).
  - On the same edge: frame_valid<=1, all captured bits clear, go to PUBLISH.
  - Publish latency: frame_valid is high in the cycle after the last digit's capture edge.
- FSM PUBLISH:
  - frame_value/frame_err are held stable while frame_valid=1.
  - frame_valid && frame_ready at an edge: frame_valid<=0, go to COLLECT.
  - Capture continues into shadow registers. If all captured bits become set while still in PUBLISH, the set is discarded (captured bits cleared) and overrun<=1.
  - Simultaneous handshake and completion on the same edge: handshake completes and the new set publishes on that edge (frame_valid stays 1, no overrun).
- frame_ready is ignored while frame_valid=0.
- overrun clears only on reset.

Optional Feature:
- SEVEN_SEGMENT_READER_BLANK_EN
- Defined: the all-off pattern 1111111 is a legal blank glyph, decoding to nibble 0 with err=0.
- Undefined: 1111111 is illegal, err=1.

Decomposition:
- Shared package seg_pkg: glyph constants SEG_0..SEG_F, SEG_BLANK, segment bit-index constants. The encoder and this reader use the same constants.
- One natural sub-module: seven_segment_glyph_decode, purely combinational: 7-bit pattern in, {err, nibble} out, with the blank-handling macro inside.
- FSM, counter and shadow registers stay in the top module.

Test Plan:
- Reset mid-PUBLISH: assert rst_n=0 while frame_valid=1 -> all outputs 0 immediately (asynchronous); shadow cleared, so a new full scan is needed before frame_valid.
- Clean scan, STABLE_CYCLES=3, 4 digits 4'h1,4'hA,4'h7,4'hF each held 3 cycles, frame_ready=1 -> frame_valid high one cycle after the 12th sample edge; frame_value=16'hF7A1, frame_err=0.
- Glitch: digit 2 shows 0100100 for 2 cycles, then 0110000 for 3 -> digit 2 captures 3, never 2.
- Illegal pattern 0101010 on digit 0 -> frame_err=4'b0001, nibble 0. 1111111 on digit 0 -> err bit set without the macro, clear with it.
- Backpressure: frame_ready=0, two complete scans -> first frame held unchanged, overrun=1 after second completion. Then frame_ready=1 -> frame_valid falls next edge.
- dig_en=4'b0011 for 10 cycles -> no capture, no frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment glyph definitions used by both the hex-to-segment encoder
// and the segment reader. Patterns are active-low, ordered segments 6..0.
package seg_pkg;

  // Segment bit positions within a 7-bit pattern.
  localparam int SEG_TOP         = 0;
  localparam int SEG_UPPER_RIGHT = 1;
  localparam int SEG_LOWER_RIGHT = 2;
  localparam int SEG_BOTTOM      = 3;
  localparam int SEG_LOWER_LEFT  = 4;
  localparam int SEG_UPPER_LEFT  = 5;
  localparam int SEG_MIDDLE      = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PUBLISH = 1'b1
  } reader_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } glyph_dec_t;

  // Forward table, kept next to the constants so encoder and reader agree.
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      default: pattern = SEG_F;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational inverse of the glyph table: 7-bit active-low pattern to {err, nibble}.
// SEVEN_SEGMENT_READER_BLANK_EN makes the all-off pattern a legal blank (nibble 0).
module seven_segment_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output glyph_dec_t dec_o
);

  always_comb begin
    dec_o.err    = 1'b0;
    dec_o.nibble = 4'h0;
    case (seg_i)
      SEG_0:     dec_o.nibble = 4'h0;
      SEG_1:     dec_o.nibble = 4'h1;
      SEG_2:     dec_o.nibble = 4'h2;
      SEG_3:     dec_o.nibble = 4'h3;
      SEG_4:     dec_o.nibble = 4'h4;
      SEG_5:     dec_o.nibble = 4'h5;
      SEG_6:     dec_o.nibble = 4'h6;
      SEG_7:     dec_o.nibble = 4'h7;
      SEG_8:     dec_o.nibble = 4'h8;
      SEG_9:     dec_o.nibble = 4'h9;
      SEG_A:     dec_o.nibble = 4'hA;
      SEG_B:     dec_o.nibble = 4'hB;
      SEG_C:     dec_o.nibble = 4'hC;
      SEG_D:     dec_o.nibble = 4'hD;
      SEG_E:     dec_o.nibble = 4'hE;
      SEG_F:     dec_o.nibble = 4'hF;
`ifdef SEVEN_SEGMENT_READER_BLANK_EN
      SEG_BLANK: dec_o.nibble = 4'h0;
`endif
      default:   dec_o.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a multiplexed 7-segment bus, debounces each digit, decodes it and publishes
// whole frames over valid/ready. Blank-glyph support: SEVEN_SEGMENT_READER_BLANK_EN.
module seven_segment_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun,
  output reader_state_t           dbg_state
);

  localparam int               CW   = 8;
  localparam logic [CW-1:0]    STAB = CW'(STABLE_CYCLES);
  localparam int               SW   = 7 + NUM_DIGITS;

  // Handshake: a frame transfers on any edge where frame_valid && frame_ready;
  // frame_value/frame_err stay frozen while frame_valid is high, and
  // frame_ready has no effect while frame_valid is low.

  logic [SW-1:0]           sample, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dig_ok, differs, capture, complete;
  logic [NUM_DIGITS-1:0]   cap_mask, captured_q, captured_next;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_err_q, sh_err_d;
  logic [4*NUM_DIGITS-1:0] frame_value_q;
  logic [NUM_DIGITS-1:0]   frame_err_q;
  logic                    frame_valid_q, overrun_q;
  reader_state_t           state_q;
  glyph_dec_t              dec;

  seven_segment_glyph_decode u_decode (
    .seg_i (seg_in),
    .dec_o (dec)
  );

  always_comb begin
    sample  = {seg_in, dig_en};
    dig_ok  = $onehot(dig_en);
    differs = (sample != prev_q);
    cnt_d   = cnt_q;
    if (!dig_ok) begin
      cnt_d = '0;
    end else if (differs) begin
      cnt_d = CW'(1);
    end else if (cnt_q < STAB) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Fire only on the edge that reaches the threshold; a saturated run stays quiet,
    // but with a threshold of 1 every new pattern is its own run.
    capture = dig_ok && (cnt_d == STAB) && (differs || (cnt_q != STAB));
  end

  always_comb begin
    cap_mask      = capture ? dig_en : '0;
    captured_next = captured_q | cap_mask;
    complete      = capture && (&captured_next);
    sh_val_d      = sh_val_q;
    sh_err_d      = sh_err_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cap_mask[k]) begin
        sh_val_d[4*k +: 4] = dec.nibble;
        sh_err_d[k]        = dec.err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= sample;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_COLLECT;
      sh_val_q      <= '0;
      sh_err_q      <= '0;
      captured_q    <= '0;
      frame_value_q <= '0;
      frame_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sh_val_q <= sh_val_d;
      sh_err_q <= sh_err_d;
      case (state_q)
        ST_COLLECT: begin
          if (complete) begin
            frame_value_q <= sh_val_d;
            frame_err_q   <= sh_err_d;
            frame_valid_q <= 1'b1;
            captured_q    <= '0;
            state_q       <= ST_PUBLISH;
          end else begin
            captured_q <= captured_next;
          end
        end
        ST_PUBLISH: begin
          if (complete) begin
            captured_q <= '0;
            if (frame_ready) begin
              // Old frame leaves and the new set takes its place on the same edge.
              frame_value_q <= sh_val_d;
              frame_err_q   <= sh_err_d;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            captured_q <= captured_next;
            if (frame_ready) begin
              frame_valid_q <= 1'b0;
              state_q       <= ST_COLLECT;
            end
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign frame_value = frame_value_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=3).
// Honours SEVEN_SEGMENT_READER_BLANK_EN for the blank-glyph expectation.
module tb_seven_segment_reader;
  import seg_pkg::*;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110;
  localparam logic [6:0] PD = 7'b0100001;
  localparam logic [6:0] PE = 7'b0000110;
  localparam logic [6:0] PF = 7'b0001110;
  localparam logic [6:0] PBAD   = 7'b0101010;
  localparam logic [6:0] PBLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_en = 4'b0000;
  logic [15:0] frame_value;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        overrun;
  reader_state_t dbg_state;

  int checks = 0;
  int failures = 0;

  seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .frame_value (frame_value),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one digit for n sample edges; returns 1 time unit after the last edge.
  task automatic hold(input int idx, input logic [6:0] pat, input int n);
    dig_en = 4'(1 << idx);
    seg_in = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dig_en = 4'b0000;
    seg_in = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Digits 0..2 fully, digit 3 one cycle short of capture.
  task automatic scan_almost(input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    hold(0, d0, 3);
    hold(1, d1, 3);
    hold(2, d2, 3);
    hold(3, d3, 2);
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                      input logic [6:0] d2, input logic [6:0] d3);
    scan_almost(d0, d1, d2, d3);
    hold(3, d3, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", frame_value, 16'h0000);
    check("reset_err", frame_err, 4'h0);
    check("reset_valid", frame_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_state", dbg_state, ST_COLLECT);
    #3 rst_n = 1'b1;
    idle(2);

    // Clean scan with ready high.
    frame_ready = 1'b1;
    scan_almost(P1, PA, P7, PF);
    check("clean_not_yet", frame_valid, 1'b0);
    hold(3, PF, 1);
    check("clean_valid", frame_valid, 1'b1);
    check("clean_value", frame_value, 16'hF7A1);
    check("clean_err", frame_err, 4'h0);
    check("clean_state", dbg_state, ST_PUBLISH);
    hold(3, PF, 1);
    check("clean_consumed", frame_valid, 1'b0);
    check("clean_back_collect", dbg_state, ST_COLLECT);
    idle(2);

    // Glitch: digit 2 shows a 2 for only two cycles before settling on 3.
    hold(0, P0, 3);
    hold(1, P5, 3);
    hold(2, P2, 2);
    hold(2, P3, 3);
    hold(3, P8, 3);
    check("glitch_valid", frame_valid, 1'b1);
    check("glitch_value", frame_value, 16'h8350);
    idle(1);
    check("glitch_consumed", frame_valid, 1'b0);

    // Illegal glyph on digit 0.
    scan(PBAD, P1, P1, P1);
    check("illegal_valid", frame_valid, 1'b1);
    check("illegal_value", frame_value, 16'h1110);
    check("illegal_err", frame_err, 4'b0001);
    idle(1);

    // All-off pattern on digit 0.
    scan(PBLANK, P1, P1, P1);
    check("blank_value", frame_value, 16'h1110);
`ifdef SEVEN_SEGMENT_READER_BLANK_EN
    check("blank_err", frame_err, 4'b0000);
`else
    check("blank_err", frame_err, 4'b0001);
`endif
    idle(1);

    // Handshake and completion on the same edge.
    frame_ready = 1'b0;
    scan(P0, P1, P2, P3);
    check("simul_first_valid", frame_valid, 1'b1);
    check("simul_first_value", frame_value, 16'h3210);
    scan_almost(P4, P5, P6, P7);
    check("simul_held_value", frame_value, 16'h3210);
    frame_ready = 1'b1;
    hold(3, P7, 1);
    check("simul_valid_stays", frame_valid, 1'b1);
    check("simul_new_value", frame_value, 16'h7654);
    check("simul_no_overrun", overrun, 1'b0);
    idle(1);
    check("simul_consumed", frame_valid, 1'b0);

    // Backpressure: second complete scan is dropped.
    frame_ready = 1'b0;
    scan(P1, P2, P3, P4);
    check("bp_first_value", frame_value, 16'h4321);
    scan_almost(P5, P6, P7, P8);
    check("bp_no_overrun_yet", overrun, 1'b0);
    hold(3, P8, 1);
    check("bp_overrun", overrun, 1'b1);
    check("bp_value_held", frame_value, 16'h4321);
    check("bp_valid_held", frame_valid, 1'b1);
    frame_ready = 1'b1;
    idle(1);
    check("bp_released", frame_valid, 1'b0);
    check("bp_overrun_sticky", overrun, 1'b1);

    // Two enables at once must never capture.
    dig_en = 4'b0011;
    seg_in = P5;
    repeat (10) @(posedge clk);
    #1;
    check("multi_en_no_valid", frame_valid, 1'b0);
    hold(1, P9, 3);
    hold(2, PA, 3);
    hold(3, PB, 3);
    check("multi_en_partial", frame_valid, 1'b0);
    hold(0, PC, 3);
    check("multi_en_complete", frame_valid, 1'b1);
    check("multi_en_value", frame_value, 16'hBA9C);
    idle(1);

    // Asynchronous reset while a frame is published and digit 0 is already re-captured.
    frame_ready = 1'b0;
    scan(PC, PD, PE, PF);
    check("rst_pre_valid", frame_valid, 1'b1);
    check("rst_pre_value", frame_value, 16'hFEDC);
    hold(0, P1, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", frame_valid, 1'b0);
    check("rst_async_value", frame_value, 16'h0000);
    check("rst_async_overrun", overrun, 1'b0);
    check("rst_async_state", dbg_state, ST_COLLECT);
    #2 rst_n = 1'b1;
    hold(1, P3, 3);
    hold(2, P4, 3);
    hold(3, P5, 3);
    check("rst_needs_full_scan", frame_valid, 1'b0);
    hold(0, P2, 3);
    check("rst_rescan_valid", frame_valid, 1'b1);
    check("rst_rescan_value", frame_value, 16'h5432);
    check("rst_rescan_err", frame_err, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
